// File: rtl/aexm_mem_arbiter.sv
// aexm_mem_arbiter
// ----------------
// Shares one external memory port between the icache refill engine (line
// reads only) and the dcache refill/writeback engine (line reads or writes).
// One requester owns the port per burst: IDLE picks an owner, CMD presents a
// single line-aligned command, XFER streams BURST_LEN beats, and DONE pulses
// the owner's done_o for one cycle.
//
// Optional feature macro: AEXM_ARB_DC_PRIO_EN
//   defined   -> dcache always wins a tie; no last-grant register
//   undefined -> round-robin on ties (dcache wins the first tie after reset)
//
// Ports
//   sys_clk_i, sys_rst_i                   clock, synchronous active-low reset
//   ic_req_i/ic_addr_i                     icache line-read request
//   ic_gnt_o/ic_rdata_o/ic_rvalid_o/ic_done_o   icache ownership, read beats, completion
//   dc_req_i/dc_we_i/dc_addr_i/dc_wdata_i  dcache request, direction, address, write beat
//   dc_wnext_o                             current dc_wdata_i consumed by memory
//   dc_gnt_o/dc_rdata_o/dc_rvalid_o/dc_done_o   dcache ownership, read beats, completion
//   mem_cmd_valid_o/ready_i/we_o/addr_o    burst command handshake to memory
//   mem_wdata_o/mem_wready_i               write beat to memory
//   mem_rdata_i/mem_rvalid_i               read beat from memory
module aexm_mem_arbiter #(
  parameter int AW        = 32,
  parameter int BURST_LEN = 4,
  parameter int BL_W      = 2
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          ic_req_i,
  input  logic [AW-1:0] ic_addr_i,
  output logic          ic_gnt_o,
  output logic [31:0]   ic_rdata_o,
  output logic          ic_rvalid_o,
  output logic          ic_done_o,
  input  logic          dc_req_i,
  input  logic          dc_we_i,
  input  logic [AW-1:0] dc_addr_i,
  input  logic [31:0]   dc_wdata_i,
  output logic          dc_wnext_o,
  output logic          dc_gnt_o,
  output logic [31:0]   dc_rdata_o,
  output logic          dc_rvalid_o,
  output logic          dc_done_o,
  output logic          mem_cmd_valid_o,
  input  logic          mem_cmd_ready_i,
  output logic          mem_cmd_we_o,
  output logic [AW-1:0] mem_cmd_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_wready_i,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_rvalid_i
);

  // A line is BURST_LEN 32-bit words, so the low BL_W+2 address bits are zero.
  localparam int ALIGN_W = BL_W + 2;
  localparam logic [AW-1:0] ALIGN_MASK = {{(AW-ALIGN_W){1'b1}}, {ALIGN_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_t;

  state_t          state_q, state_d;
  logic            owner_dc_q, owner_dc_d;   // 1 = dcache owns the port
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BL_W-1:0] cnt_q, cnt_d;

  logic            pick_dc;
  logic            beat;
  logic            last_beat;

`ifdef AEXM_ARB_DC_PRIO_EN
  assign pick_dc = dc_req_i;
`else
  // last_dc_q records who finished the previous burst; on a tie the other wins.
  logic last_dc_q, last_dc_d;

  assign pick_dc   = dc_req_i & (~ic_req_i | ~last_dc_q);
  assign last_dc_d = (state_q == DONE) ? owner_dc_q : last_dc_q;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      last_dc_q <= 1'b0;
    end else begin
      last_dc_q <= last_dc_d;
    end
  end
`endif

  // A beat is a handshake in the burst's own direction; the other strobe is noise.
  assign beat      = (state_q == XFER) & (we_q ? mem_wready_i : mem_rvalid_i);
  assign last_beat = beat & (cnt_q == BL_W'(BURST_LEN - 1));

  // State register
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      state_q    <= IDLE;
      owner_dc_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    owner_dc_d = owner_dc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (ic_req_i | dc_req_i) begin
          state_d    = CMD;
          owner_dc_d = pick_dc;
          we_d       = pick_dc & dc_we_i;
          addr_d     = (pick_dc ? dc_addr_i : ic_addr_i) & ALIGN_MASK;
        end
      end
      CMD: begin
        if (mem_cmd_ready_i) begin
          state_d = XFER;
          cnt_d   = '0;
        end
      end
      XFER: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;   // wraps to 0 on the last beat
        end
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: beats are forwarded combinationally for zero-latency delivery.
  always_comb begin
    ic_gnt_o        = 1'b0;
    ic_rdata_o      = '0;
    ic_rvalid_o     = 1'b0;
    ic_done_o       = 1'b0;
    dc_gnt_o        = 1'b0;
    dc_rdata_o      = '0;
    dc_rvalid_o     = 1'b0;
    dc_done_o       = 1'b0;
    dc_wnext_o      = 1'b0;
    mem_cmd_valid_o = 1'b0;
    mem_cmd_we_o    = 1'b0;
    mem_cmd_addr_o  = '0;
    mem_wdata_o     = '0;
    case (state_q)
      CMD: begin
        ic_gnt_o        = ~owner_dc_q;
        dc_gnt_o        = owner_dc_q;
        mem_cmd_valid_o = 1'b1;
        mem_cmd_we_o    = we_q;
        mem_cmd_addr_o  = addr_q;
      end
      XFER: begin
        ic_gnt_o = ~owner_dc_q;
        dc_gnt_o = owner_dc_q;
        if (we_q) begin
          mem_wdata_o = dc_wdata_i;
          dc_wnext_o  = mem_wready_i;
        end else if (owner_dc_q) begin
          dc_rdata_o  = mem_rdata_i;
          dc_rvalid_o = mem_rvalid_i;
        end else begin
          ic_rdata_o  = mem_rdata_i;
          ic_rvalid_o = mem_rvalid_i;
        end
      end
      DONE: begin
        ic_done_o = ~owner_dc_q;
        dc_done_o = owner_dc_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/aexm_mem_arbiter.md
Name: aexm_mem_arbiter

Overview:
Shares one external memory port between the aeMB instruction-cache refill engine and the data-cache refill/writeback engine. Each cache issues a burst request for one aligned cache line. The arbiter grants one requester at a time and issues one command to memory. It streams BURST_LEN data beats between memory and the granted cache, then signals completion. It sits between the two cache controllers and the SDRAM/bus front-end, below the core's cache busy/enable handshake.

Parameters:
AW, 32, address width of requests and memory command
BURST_LEN, 4, data beats per line transfer (power of two, 2..16)
BL_W, 2, width of beat counter = log2(BURST_LEN)

Ports:
sys_clk_i  in  1  system clock
sys_rst_i  in  1  synchronous reset, active-low
ic_req_i  in  1  icache line-read request, held until ic_done_o
ic_addr_i  in  AW  icache line address
ic_gnt_o  out  1  icache currently owns memory port
ic_rdata_o  out  32  read beat to icache
ic_rvalid_o  out  1  ic_rdata_o valid this cycle
ic_done_o  out  1  one-cycle pulse, icache transfer complete
dc_req_i  in  1  dcache request, held until dc_done_o
dc_we_i  in  1  1 = line writeback, 0 = line read
dc_addr_i  in  AW  dcache line address
dc_wdata_i  in  32  write beat from dcache
dc_wnext_o  out  1  current dc_wdata_i consumed; dcache advances to next beat
dc_gnt_o  out  1  dcache owns memory port
dc_rdata_o  out  32  read beat to dcache
dc_rvalid_o  out  1  dc_rdata_o valid
dc_done_o  out  1  one-cycle completion pulse
mem_cmd_valid_o  out  1  command valid
mem_cmd_ready_i  in  1  memory accepts command
mem_cmd_we_o  out  1  command is write burst
mem_cmd_addr_o  out  AW  burst start address, low log2(BURST_LEN)+2 bits forced 0
mem_wdata_o  out  32  write beat
mem_wready_i  in  1  memory accepts write beat this cycle
mem_rdata_i  in  32  read beat
mem_rvalid_i  in  1  read beat valid

Behaviour:
- Reset (sys_rst_i==0 at clock edge): state IDLE, all outputs 0, beat counter 0, last-grant = icache (so dcache wins the first tie).
- States: IDLE, CMD, XFER, DONE.
- IDLE:
  - Sample requests. Only one request -> grant it. Both -> grant the one not granted last (round-robin).
  - Latch owner, we (icache always 0) and aligned address.
  - Next state CMD; gnt_o for the owner rises on the cycle CMD is entered.
- CMD:
  - mem_cmd_valid_o=1 with stable addr/we until mem_cmd_ready_i=1.
  - Then go to XFER, counter=0.
  - Requests withdrawn in CMD are ignored; the command completes.
- XFER read:
  - Each mem_rvalid_i cycle, forward mem_rdata_i combinationally to the owner's rdata_o and assert rvalid_o the same cycle (0 latency). Increment counter.
  - Non-owner rvalid stays 0.
- XFER write:
  - mem_wdata_o = dc_wdata_i combinationally.
  - Each mem_wready_i cycle asserts dc_wnext_o the same cycle; increment counter.
- Exit XFER on the beat where counter==BURST_LEN-1 is transferred; go to DONE. Counter wraps to 0.
- DONE: owner done_o=1 for exactly one cycle, gnt_o drops, last-grant updated, return to IDLE.
  - A requester must drop req the cycle after done; a req still high in IDLE is treated as a new request.
- Minimum turnaround: 2 idle cycles between bursts (DONE, IDLE).
- mem_rvalid_i outside XFER, or during a write burst: ignored. mem_wready_i during a read burst: ignored.
- Reset mid-burst: immediate return to IDLE, no done pulse. The memory side must also be reset.

Optional Feature:
AEXM_ARB_DC_PRIO_EN:
- Defined: fixed priority; dcache always wins a tie in IDLE and the last-grant register is removed.
- Undefined: round-robin as above.

Test Plan:
- Single icache read, addr 0x0000_1234, BURST_LEN=4, ready same cycle, rdata 0xA0..0xA3 on consecutive cycles -> cmd_addr 0x0000_1230, we=0, ic_rvalid_o 4 cycles with 0xA0..0xA3, ic_done_o 1 cycle later, dc outputs stay 0.
- Dcache writeback addr 0x8000_0040, wdata D0..D3, mem_wready_i toggling 1,0,1,0,1,1 -> cmd we=1, dc_wnext_o exactly on the 4 wready cycles, mem_wdata_o matches D0..D3, dc_done_o after the 4th beat.
- Both request simultaneously from reset, held -> dcache granted first, then icache, then dcache again (round-robin). With AEXM_ARB_DC_PRIO_EN defined: dcache granted every tie.
- mem_cmd_ready_i held low 5 cycles -> cmd_valid/addr stable for all 5 cycles, no beats forwarded, then normal transfer.
- Spurious mem_rvalid_i in IDLE and during write burst -> no rvalid_o, counter unchanged.
- Reset asserted on beat 2 of a read -> next cycle all outputs 0, no done pulse, a new icache req is granted normally.
